polar_to_rect: RTL and testbench
================================

Name: polar_to_rect

Overview:
- Inverse of the localization rectangular-to-polar stage: converts per-channel (magnitude, phase) words back to (X, Y) Cartesian.
- Uses an iterative CORDIC in rotation mode; each channel has its own datapath, and all channels share one FSM.
- Sits between the beamforming phase-adjust logic and the IFFT input.
- Uses the same fixed-point formats the forward conversion produces, so its outputs can be fed back unmodified.

Parameters:
- CHANNELS, 4, number of parallel channels.
- DATA_WIDTH, 32, bits per channel word. Each half is DATA_WIDTH/2 wide. Must be even and ≥ 16.
- ITERATIONS, 12, number of CORDIC micro-rotations. Legal range 1..14.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  synchronous, active-high reset.
- data_in  input  DATA_WIDTH x CHANNELS (unpacked array [CHANNELS-1:0])  per channel: [DATA_WIDTH/2-1:0] magnitude, signed 1QN (Q2.14); [DATA_WIDTH-1:DATA_WIDTH/2] phase in radians, signed 2QN (Q3.13).
- valid_in  input  1  input word valid.
- ready_out  output  1  block can accept an input.
- data_out  output  CHANNELS*DATA_WIDTH (packed; channel i at [DATA_WIDTH*i +: DATA_WIDTH])  per channel: [low half] X, [high half] Y, both signed Q2.14.
- valid_out  output  1  result valid.
- ready_in  input  1  downstream accepts the result.

Behaviour:
- Clock/reset: one clock, clk_in. Reset rst_in is synchronous, active-high.
- Reset values: state=IDLE, valid_out=0, data_out=0. ready_out=0 during any cycle rst_in is high, then 1 from the first cycle after reset.
- FSM states: IDLE, ITER, SCALE (present only with GAIN_COMP_EN), DONE.
- ready_out = (state==IDLE) && !rst_in, decoded combinationally from registered state.
- IDLE:
  - A transfer occurs when valid_in && ready_out.
  - On transfer, register the folded start vector for every channel, set the iteration counter to 0, go to ITER.
  - When valid_in is low, stay in IDLE.
- Quadrant fold, per channel:
  - Phase is first clamped to [-PI, +PI], where PI = 0x6488.
  - If phase > HALF_PI (0x3244): x0=0, y0=mag, z0=phase-HALF_PI.
  - If phase < -HALF_PI: x0=0, y0=-mag, z0=phase+HALF_PI.
  - Otherwise: x0=mag, y0=0, z0=phase.
- ITER, micro-rotation i:
  - d = sign(z); d=+1 when z ≥ 0.
  - x' = x - d*(y>>>i)
  - y' = y + d*(x>>>i)
  - z' = z - d*ATAN[i]
  - ATAN[i] = round(atan(2^-i)*8192), taken from a constant ROM.
  - Shifts are arithmetic and truncating.
  - Internal x/y width is DATA_WIDTH/2+2 (guard bits); z width is DATA_WIDTH/2+1.
  - After ITERATIONS cycles, go to SCALE if present, else to DONE.
- SCALE (GAIN_COMP_EN only): one cycle; x,y multiplied by INV_K = 0x4DBA (Q1.15), product shifted right by 15.
- DONE:
  - data_out registered with x,y saturated to signed DATA_WIDTH/2; valid_out=1.
  - data_out and valid_out hold stable until ready_in is high. In that cycle valid_out clears and state returns to IDLE.
  - The next input cannot be accepted in that same cycle; ready_out rises the following cycle.
- Latency, from the handshake cycle to the first valid_out cycle: ITERATIONS+1 cycles, or ITERATIONS+2 with GAIN_COMP_EN.
- Throughput: one conversion per latency+1 cycles when ready_in is held high.
- valid_in while busy: ignored, no capture, no error.
- Reset mid-operation (any state): abort on the next edge with reset values. Any partially computed result is discarded and never presented.
- All channels complete in the same cycle; there is no per-channel valid.

Optional Feature:
- Macro: POLAR_TO_RECT_GAIN_COMP_EN.
- Defined: SCALE state and INV_K multiplier per channel are present. Output magnitude ≈ input magnitude.
- Undefined: no SCALE state and no multipliers. Output is scaled by K ≈ 1.6468, matching the forward conversion, which leaves its magnitude unscaled.

Test Plan:
- Gain comp off, ch0 mag=0x2000 phase=0x0000 -> X=0x34B2 ±4 LSB, Y=0x0000 ±4; valid_out exactly 13 cycles after handshake.
- Gain comp on, phases 0x3244 / 0x6488 / 0xCDBC / 0x1922 (PI/4) on ch0..3, mag 0x2000 -> (X,Y) ≈ (0,0x2000), (0xE000,0), (0,0xE000), (0x16A1,0x16A1) ±4 LSB; latency 14.
- Backpressure: ready_in low 5 cycles in DONE, valid_in pulsed -> valid_out and data_out stable, ready_out=0, no capture; ready_in=1 -> valid_out drops, ready_out=1 next cycle.
- Reset asserted at ITER cycle 5 -> next cycle valid_out=0, data_out=0, ready_out=0; IDLE after release; next conversion correct.
- Saturation/clamp: gain off, mag=0x7FFF phase=0 -> X saturates to 0x7FFF. Phase=0x7000 -> treated as PI, X ≈ -mag*K.
- Back-to-back with ready_in tied high, 8 random vectors -> 8 results in order, each within ±6 LSB of the double-precision model.

Source files
------------

// File: rtl/polar_to_rect.sv
`default_nettype none
// ============================================================================
// Module   : polar_to_rect
// Purpose  : Iterative rotation-mode CORDIC, per-channel (magnitude, phase)
//            to (X, Y). Macro POLAR_TO_RECT_GAIN_COMP_EN adds a 1/K SCALE cycle.
// Revision : 1.0
// ============================================================================
module polar_to_rect #(
    parameter int CHANNELS   = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ITERATIONS = 12
) (
    input  logic                           clk_in,
    input  logic                           rst_in,
    input  logic [DATA_WIDTH-1:0]          data_in [CHANNELS-1:0],
    input  logic                           valid_in,
    output logic                           ready_out,
    output logic [CHANNELS*DATA_WIDTH-1:0] data_out,
    output logic                           valid_out,
    input  logic                           ready_in
);
    localparam int HW = DATA_WIDTH / 2;
    localparam int XW = HW + 2;
    localparam int ZW = HW + 1;
    localparam int CW = 4;

    localparam logic signed [ZW-1:0] PI_Z          = ZW'(25736);
    localparam logic signed [ZW-1:0] NEG_PI_Z      = ZW'(-25736);
    localparam logic signed [ZW-1:0] HALF_PI_Z     = ZW'(12868);
    localparam logic signed [ZW-1:0] NEG_HALF_PI_Z = ZW'(-12868);
    localparam logic signed [XW-1:0] SAT_MAX       = XW'((1 << (HW - 1)) - 1);
    localparam logic signed [XW-1:0] SAT_MIN       = XW'(-(1 << (HW - 1)));

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ITER  = 2'd1;
`ifdef POLAR_TO_RECT_GAIN_COMP_EN
    localparam logic [1:0] S_SCALE = 2'd2;
    localparam logic signed [16:0] INV_K = 17'sd19898;
`endif
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]    state;
    logic [1:0]    state_nx;
    logic [CW-1:0] iter_cnt;
    logic          load_start;
    logic          do_iter;
    logic          last_iter;
    logic          load_out;

    function automatic logic signed [ZW-1:0] atan_rom(input logic [CW-1:0] idx);
        case (idx)
            4'd0:    atan_rom = ZW'(6434);
            4'd1:    atan_rom = ZW'(3798);
            4'd2:    atan_rom = ZW'(2007);
            4'd3:    atan_rom = ZW'(1019);
            4'd4:    atan_rom = ZW'(511);
            4'd5:    atan_rom = ZW'(256);
            4'd6:    atan_rom = ZW'(128);
            4'd7:    atan_rom = ZW'(64);
            4'd8:    atan_rom = ZW'(32);
            4'd9:    atan_rom = ZW'(16);
            4'd10:   atan_rom = ZW'(8);
            4'd11:   atan_rom = ZW'(4);
            4'd12:   atan_rom = ZW'(2);
            default: atan_rom = ZW'(1);
        endcase
    endfunction

    function automatic logic [HW-1:0] sat(input logic signed [XW-1:0] v);
        logic signed [XW-1:0] t;
        t = v;
        if (v > SAT_MAX)      t = SAT_MAX;
        else if (v < SAT_MIN) t = SAT_MIN;
        sat = t[HW-1:0];
    endfunction

    always_ff @(posedge clk_in) begin
        if (rst_in) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (valid_in) state_nx = S_ITER;
`ifdef POLAR_TO_RECT_GAIN_COMP_EN
            S_ITER:  if (last_iter) state_nx = S_SCALE;
            S_SCALE: state_nx = S_DONE;
`else
            S_ITER:  if (last_iter) state_nx = S_DONE;
`endif
            S_DONE:  if (ready_in) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        ready_out  = (state == S_IDLE) && !rst_in;
        valid_out  = (state == S_DONE);
        load_start = ready_out && valid_in;
        do_iter    = (state == S_ITER);
        last_iter  = do_iter && (iter_cnt == CW'(ITERATIONS - 1));
`ifdef POLAR_TO_RECT_GAIN_COMP_EN
        load_out   = (state == S_SCALE);
`else
        load_out   = last_iter;
`endif
    end

    always_ff @(posedge clk_in) begin
        if (rst_in || load_start)     iter_cnt <= '0;
        else if (do_iter && !last_iter) iter_cnt <= iter_cnt + CW'(1);
    end

    generate
        for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
            logic signed [HW-1:0] mag;
            logic signed [HW-1:0] phase;
            logic signed [ZW-1:0] ph_c;
            logic signed [XW-1:0] x0, y0, x, y, x_sh, y_sh, x_nx, y_nx, x_fin, y_fin;
            logic signed [ZW-1:0] z0, z, z_nx, ang;
            logic [DATA_WIDTH-1:0] out_q;

            assign mag   = data_in[g][HW-1:0];
            assign phase = data_in[g][DATA_WIDTH-1:HW];

            // Clamp to [-PI, PI], then fold into the CORDIC convergence range
            always_comb begin
                ph_c = ZW'(phase);
                if (ph_c > PI_Z)          ph_c = PI_Z;
                else if (ph_c < NEG_PI_Z) ph_c = NEG_PI_Z;
                x0 = XW'(mag);
                y0 = '0;
                z0 = ph_c;
                if (ph_c > HALF_PI_Z) begin
                    x0 = '0;
                    y0 = XW'(mag);
                    z0 = ph_c - HALF_PI_Z;
                end else if (ph_c < NEG_HALF_PI_Z) begin
                    x0 = '0;
                    y0 = -XW'(mag);
                    z0 = ph_c + HALF_PI_Z;
                end
            end

            always_comb begin
                x_sh = x >>> iter_cnt;
                y_sh = y >>> iter_cnt;
                ang  = atan_rom(iter_cnt);
                if (!z[ZW-1]) begin
                    x_nx = x - y_sh;
                    y_nx = y + x_sh;
                    z_nx = z - ang;
                end else begin
                    x_nx = x + y_sh;
                    y_nx = y - x_sh;
                    z_nx = z + ang;
                end
            end

            always_ff @(posedge clk_in) begin
                if (rst_in) begin
                    x <= '0;
                    y <= '0;
                    z <= '0;
                end else if (load_start) begin
                    x <= x0;
                    y <= y0;
                    z <= z0;
                end else if (do_iter) begin
                    x <= x_nx;
                    y <= y_nx;
                    z <= z_nx;
                end
            end

`ifdef POLAR_TO_RECT_GAIN_COMP_EN
            logic signed [XW+16:0] x_prod;
            logic signed [XW+16:0] y_prod;
            assign x_prod = x * INV_K;
            assign y_prod = y * INV_K;
            assign x_fin  = x_prod[XW+14:15];
            assign y_fin  = y_prod[XW+14:15];
`else
            assign x_fin  = x_nx;
            assign y_fin  = y_nx;
`endif

            always_ff @(posedge clk_in) begin
                if (rst_in)        out_q <= '0;
                else if (load_out) out_q <= {sat(y_fin), sat(x_fin)};
            end

            assign data_out[DATA_WIDTH*g +: DATA_WIDTH] = out_q;
        end
    endgenerate
endmodule
`default_nettype wire

// File: tb/tb_polar_to_rect.sv
`default_nettype none
// ============================================================================
// Module   : tb_polar_to_rect
// Purpose  : Randomized bench for polar_to_rect against a trig reference model.
// Revision : 1.0
// ============================================================================
module tb_polar_to_rect;
    localparam int CH = 4;
    localparam int DW = 32;
    localparam int IT = 12;
`ifdef POLAR_TO_RECT_GAIN_COMP_EN
    localparam int LAT = IT + 2;
`else
    localparam int LAT = IT + 1;
`endif

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic [DW-1:0] data_in [CH-1:0];
    logic          valid_in;
    logic          ready_out;
    logic [CH*DW-1:0] data_out;
    logic          valid_out;
    logic          ready_in;

    int  checks = 0;
    int  errors = 0;
    real gain;

    polar_to_rect #(.CHANNELS(CH), .DATA_WIDTH(DW), .ITERATIONS(IT)) dut (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .data_in  (data_in),
        .valid_in (valid_in),
        .ready_out(ready_out),
        .data_out (data_out),
        .valid_out(valid_out),
        .ready_in (ready_in)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    function automatic int s16(input logic [15:0] v);
        return int'($signed(v));
    endfunction

    function automatic int xo(input int c);
        return s16(data_out[c*DW +: 16]);
    endfunction

    function automatic int yo(input int c);
        return s16(data_out[c*DW+16 +: 16]);
    endfunction

    function automatic int absd(input int a, input int b);
        return (a > b) ? a - b : b - a;
    endfunction

    function automatic int clip16(input real r);
        int v;
        v = int'(r);
        if (v > 32767)  v = 32767;
        if (v < -32768) v = -32768;
        return v;
    endfunction

    // Ideal polar-to-rectangular conversion with the CORDIC gain (or residual gain) applied
    function automatic void model(input logic [15:0] mag, input logic [15:0] ph,
                                  output int ex, output int ey);
        real p, m;
        p = real'(s16(ph));
        if (p > 25736.0)  p = 25736.0;
        if (p < -25736.0) p = -25736.0;
        m  = real'(s16(mag));
        ex = clip16(m * gain * $cos(p / 8192.0));
        ey = clip16(m * gain * $sin(p / 8192.0));
    endfunction

    function automatic logic [15:0] rand_mag();
        int v;
        v = int'($urandom_range(4096)) - 2048;
        return v[15:0];
    endfunction

    task automatic start_conv(output bit ok);
        int n;
        n = 0;
        while (!ready_out && n < 50) begin
            tick();
            n++;
        end
        ok = ready_out;
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 1;
        while (!valid_out && lat < 200) begin
            tick();
            lat++;
        end
        if (!valid_out) lat = -1;
    endtask

    task automatic release_result();
        ready_in = 1'b1;
        tick();
        ready_in = 1'b0;
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        tick();
        tick();
        checks++;
        if (ready_out !== 1'b0) begin errors++; $display("FAIL reset_ready actual=%b required=0", ready_out); end
        checks++;
        if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid actual=%b required=0", valid_out); end
        checks++;
        if (data_out !== '0) begin errors++; $display("FAIL reset_data actual=%h required=0", data_out); end
        rst_in = 1'b0;
        tick();
        checks++;
        if (ready_out !== 1'b1) begin errors++; $display("FAIL reset_release_ready actual=%b required=1", ready_out); end
    endtask

    task automatic test_random_conv(input string name, input logic [15:0] m [CH], input logic [15:0] p [CH]);
        bit ok;
        int lat, ex, ey;
        for (int c = 0; c < CH; c++) data_in[c] = {p[c], m[c]};
        start_conv(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL %s_handshake actual=0 required=1", name); end
        wait_valid(lat);
        checks++;
        if (lat != LAT) begin errors++; $display("FAIL %s_latency actual=%0d required=%0d", name, lat, LAT); end
        for (int c = 0; c < CH; c++) begin
            model(m[c], p[c], ex, ey);
            checks++;
            if (absd(xo(c), ex) > 6) begin errors++; $display("FAIL %s_x%0d actual=%0d required=%0d+-6", name, c, xo(c), ex); end
            checks++;
            if (absd(yo(c), ey) > 6) begin errors++; $display("FAIL %s_y%0d actual=%0d required=%0d+-6", name, c, yo(c), ey); end
        end
        release_result();
    endtask

`ifndef POLAR_TO_RECT_GAIN_COMP_EN
    task automatic test_basic();
        bit ok;
        int lat, ex, ey;
        logic [15:0] m [CH];
        logic [15:0] p [CH];
        m[0] = 16'h2000;
        p[0] = 16'h0000;
        for (int c = 1; c < CH; c++) begin m[c] = rand_mag(); p[c] = 16'($urandom); end
        for (int c = 0; c < CH; c++) data_in[c] = {p[c], m[c]};
        start_conv(ok);
        wait_valid(lat);
        checks++;
        if (lat != 13) begin errors++; $display("FAIL basic_latency actual=%0d required=13", lat); end
        checks++;
        if (absd(xo(0), 13490) > 4) begin errors++; $display("FAIL basic_x0 actual=%0d required=13490+-4", xo(0)); end
        checks++;
        if (absd(yo(0), 0) > 4) begin errors++; $display("FAIL basic_y0 actual=%0d required=0+-4", yo(0)); end
        for (int c = 1; c < CH; c++) begin
            model(m[c], p[c], ex, ey);
            checks++;
            if (absd(xo(c), ex) > 6) begin errors++; $display("FAIL basic_x%0d actual=%0d required=%0d+-6", c, xo(c), ex); end
            checks++;
            if (absd(yo(c), ey) > 6) begin errors++; $display("FAIL basic_y%0d actual=%0d required=%0d+-6", c, yo(c), ey); end
        end
        release_result();
    endtask
`else
    task automatic test_gain_phases();
        bit ok;
        int lat;
        int ex [CH];
        int ey [CH];
        logic [15:0] p [CH];
        p[0] = 16'h3244; p[1] = 16'h6488; p[2] = 16'hCDBC; p[3] = 16'h1922;
        ex[0] = 0;     ey[0] = 8192;
        ex[1] = -8192; ey[1] = 0;
        ex[2] = 0;     ey[2] = -8192;
        ex[3] = 5793;  ey[3] = 5793;
        for (int c = 0; c < CH; c++) data_in[c] = {p[c], 16'h2000};
        start_conv(ok);
        wait_valid(lat);
        checks++;
        if (lat != 14) begin errors++; $display("FAIL gain_latency actual=%0d required=14", lat); end
        for (int c = 0; c < CH; c++) begin
            checks++;
            if (absd(xo(c), ex[c]) > 4) begin errors++; $display("FAIL gain_x%0d actual=%0d required=%0d+-4", c, xo(c), ex[c]); end
            checks++;
            if (absd(yo(c), ey[c]) > 4) begin errors++; $display("FAIL gain_y%0d actual=%0d required=%0d+-4", c, yo(c), ey[c]); end
        end
        release_result();
    endtask
`endif

    task automatic test_sat_clamp();
        bit ok;
        int lat, ex, ey;
        data_in[0] = {16'h0000, 16'h7FFF};
        data_in[1] = {16'h7000, 16'h1000};
        data_in[2] = {16'h9000, 16'h1000};
        data_in[3] = {16'h6488, 16'h0800};
        start_conv(ok);
        wait_valid(lat);
`ifndef POLAR_TO_RECT_GAIN_COMP_EN
        checks++;
        if (data_out[15:0] !== 16'h7FFF) begin errors++; $display("FAIL sat_x0 actual=%h required=7fff", data_out[15:0]); end
`endif
        for (int c = 1; c < CH; c++) begin
            model(data_in[c][15:0], data_in[c][31:16], ex, ey);
            checks++;
            if (absd(xo(c), ex) > 6) begin errors++; $display("FAIL clamp_x%0d actual=%0d required=%0d+-6", c, xo(c), ex); end
        end
        release_result();
    endtask

    task automatic test_backpressure();
        bit ok;
        int lat;
        logic [CH*DW-1:0] snap;
        for (int c = 0; c < CH; c++) data_in[c] = {16'($urandom), rand_mag()};
        start_conv(ok);
        wait_valid(lat);
        snap = data_out;
        for (int k = 0; k < 5; k++) begin
            valid_in = 1'b1;
            data_in[0] = {16'($urandom), rand_mag()};
            tick();
            checks++;
            if (valid_out !== 1'b1) begin errors++; $display("FAIL bp_valid_hold actual=%b required=1", valid_out); end
            checks++;
            if (data_out !== snap) begin errors++; $display("FAIL bp_data_hold actual=%h required=%h", data_out, snap); end
            checks++;
            if (ready_out !== 1'b0) begin errors++; $display("FAIL bp_ready_busy actual=%b required=0", ready_out); end
        end
        valid_in = 1'b0;
        ready_in = 1'b1;
        tick();
        ready_in = 1'b0;
        checks++;
        if (valid_out !== 1'b0) begin errors++; $display("FAIL bp_valid_drop actual=%b required=0", valid_out); end
        checks++;
        if (ready_out !== 1'b1) begin errors++; $display("FAIL bp_ready_rise actual=%b required=1", ready_out); end
        lat = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (valid_out) lat++;
        end
        checks++;
        if (lat != 0) begin errors++; $display("FAIL bp_no_capture actual=%0d required=0 valid cycles", lat); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int vcnt;
        logic [15:0] m [CH];
        logic [15:0] p [CH];
        for (int c = 0; c < CH; c++) data_in[c] = {16'($urandom), rand_mag()};
        start_conv(ok);
        for (int k = 0; k < 5; k++) tick();
        rst_in = 1'b1;
        checks++;
        if (ready_out !== 1'b0) begin errors++; $display("FAIL rmid_ready_in_reset actual=%b required=0", ready_out); end
        tick();
        checks++;
        if (valid_out !== 1'b0) begin errors++; $display("FAIL rmid_valid actual=%b required=0", valid_out); end
        checks++;
        if (data_out !== '0) begin errors++; $display("FAIL rmid_data actual=%h required=0", data_out); end
        checks++;
        if (ready_out !== 1'b0) begin errors++; $display("FAIL rmid_ready actual=%b required=0", ready_out); end
        rst_in = 1'b0;
        tick();
        checks++;
        if (ready_out !== 1'b1) begin errors++; $display("FAIL rmid_idle actual=%b required=1", ready_out); end
        vcnt = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (valid_out) vcnt++;
        end
        checks++;
        if (vcnt != 0) begin errors++; $display("FAIL rmid_no_result actual=%0d required=0 valid cycles", vcnt); end
        for (int c = 0; c < CH; c++) begin m[c] = rand_mag(); p[c] = 16'($urandom); end
        test_random_conv("rmid_next", m, p);
    endtask

    task automatic test_back_to_back();
        logic [15:0] bm [8][CH];
        logic [15:0] bp [8][CH];
        int idx, res, ex, ey, last_t, t;
        bit acc;
        for (int v = 0; v < 8; v++)
            for (int c = 0; c < CH; c++) begin bm[v][c] = rand_mag(); bp[v][c] = 16'($urandom); end
        idx = 0;
        res = 0;
        last_t = -1;
        t = 0;
        ready_in = 1'b1;
        valid_in = 1'b1;
        for (int c = 0; c < CH; c++) data_in[c] = {bp[0][c], bm[0][c]};
        while (res < 8 && t < 400) begin
            if (valid_out) begin
                for (int c = 0; c < CH; c++) begin
                    model(bm[res][c], bp[res][c], ex, ey);
                    checks++;
                    if (absd(xo(c), ex) > 6) begin errors++; $display("FAIL b2b_x r%0d c%0d actual=%0d required=%0d+-6", res, c, xo(c), ex); end
                    checks++;
                    if (absd(yo(c), ey) > 6) begin errors++; $display("FAIL b2b_y r%0d c%0d actual=%0d required=%0d+-6", res, c, yo(c), ey); end
                end
                if (last_t >= 0) begin
                    checks++;
                    if (t - last_t != LAT + 1) begin errors++; $display("FAIL b2b_period actual=%0d required=%0d", t - last_t, LAT + 1); end
                end
                last_t = t;
                res++;
            end
            acc = ready_out && valid_in;
            tick();
            t++;
            if (acc) begin
                idx++;
                if (idx < 8) for (int c = 0; c < CH; c++) data_in[c] = {bp[idx][c], bm[idx][c]};
                else valid_in = 1'b0;
            end
        end
        checks++;
        if (res != 8) begin errors++; $display("FAIL b2b_count actual=%0d required=8", res); end
        ready_in = 1'b0;
        valid_in = 1'b0;
        tick();
    endtask

    initial begin
        real k;
        logic [15:0] m [CH];
        logic [15:0] p [CH];
        k = 1.0;
        for (int i = 0; i < IT; i++) k = k * $sqrt(1.0 + $pow(2.0, -2.0 * i));
`ifdef POLAR_TO_RECT_GAIN_COMP_EN
        gain = k * 19898.0 / 32768.0;
`else
        gain = k;
`endif
        rst_in   = 1'b1;
        valid_in = 1'b0;
        ready_in = 1'b0;
        for (int c = 0; c < CH; c++) data_in[c] = '0;

        test_reset();
`ifndef POLAR_TO_RECT_GAIN_COMP_EN
        test_basic();
`else
        test_gain_phases();
`endif
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < CH; c++) begin m[c] = rand_mag(); p[c] = 16'($urandom); end
            test_random_conv("rand", m, p);
        end
        test_sat_clamp();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
